// File: rtl/dma_state_seq.sv
// Sequential half of the DMA engine: holds the present state for the external
// next-state decoder and applies its active-low address/counter controls.
module dma_state_seq #(
    parameter int unsigned AW       = 16,
    parameter int unsigned XW       = 8,
    parameter int unsigned YW       = 8,
    parameter int unsigned PB       = 8,
    parameter logic [3:0]  START_ST = 4'b0001
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          cfg_rmw,
    input  logic [AW-1:0] cfg_base,
    input  logic [XW-1:0] cfg_xlen,
    input  logic [YW-1:0] cfg_ylen,
    input  logic          mem_rdy,
    input  logic [3:0]    dmnst_b,
    input  logic [2:0]    adctlp_b,
    output logic [3:0]    dmpst,
    output logic          rmwb,
    output logic          xskip,
    output logic          yskip,
    output logic          page,
    output logic [AW-1:0] mem_addr,
    output logic          mem_req,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic {
        PH_IDLE,
        PH_RUN
    } phase_t;

    phase_t        phase;
    logic [XW-1:0] x_cnt;
    logic [XW-1:0] xlen_q;
    logic [YW-1:0] y_cnt;
    logic [3:0]    nst;
    logic [AW-PB-1:0] page_next;

    assign nst       = ~dmnst_b;
    assign busy      = (phase == PH_RUN);
    assign mem_req   = busy;
    assign page_next = mem_addr[AW-1:PB] + (AW-PB)'(1);

    // Conditions depend only on registered state, keeping the decoder loop one cycle.
    assign xskip = (x_cnt == '0);
    assign yskip = (y_cnt == '0);
    assign page  = &mem_addr[PB-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase    <= PH_IDLE;
            dmpst    <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            rmwb     <= 1'b1;
            mem_addr <= '0;
            x_cnt    <= '0;
            y_cnt    <= '0;
            xlen_q   <= '0;
        end else begin
            done <= 1'b0;
            if (phase == PH_IDLE) begin
                if (start) begin
                    phase    <= PH_RUN;
                    dmpst    <= START_ST;
                    mem_addr <= cfg_base;
                    x_cnt    <= cfg_xlen;
                    xlen_q   <= cfg_xlen;
                    y_cnt    <= cfg_ylen;
                    rmwb     <= ~cfg_rmw;
                    err      <= 1'b0;
                end
            end else if (mem_rdy) begin
                if (nst == 4'b0000) begin
                    phase <= PH_IDLE;
                    dmpst <= '0;
                    done  <= 1'b1;
                end else if (nst == 4'b1111) begin
                    phase <= PH_IDLE;
                    dmpst <= '0;
                    err   <= 1'b1;
                end else begin
                    dmpst <= nst;
                end

                if (!adctlp_b[2])
                    mem_addr <= {page_next, {PB{1'b0}}};
                else if (!adctlp_b[0])
                    mem_addr <= mem_addr + AW'(1);

                // Row advance reloads X and wins over the per-beat X decrement.
                if (!adctlp_b[1]) begin
                    x_cnt <= xlen_q;
                    if (y_cnt != '0)
                        y_cnt <= y_cnt - YW'(1);
                end else if (!adctlp_b[0]) begin
                    if (x_cnt != '0)
                        x_cnt <= x_cnt - XW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_dma_state_seq.sv
// Directed bench for dma_state_seq: start latch, counters, page crossing,
// stall, completion, illegal-state error and mid-transfer reset.
module tb_dma_state_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        cfg_rmw;
    logic [15:0] cfg_base;
    logic [7:0]  cfg_xlen;
    logic [7:0]  cfg_ylen;
    logic        mem_rdy;
    logic [3:0]  dmnst_b;
    logic [2:0]  adctlp_b;
    logic [3:0]  dmpst;
    logic        rmwb;
    logic        xskip;
    logic        yskip;
    logic        page;
    logic [15:0] mem_addr;
    logic        mem_req;
    logic        busy;
    logic        done;
    logic        err;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    dma_state_seq #(
        .AW(16), .XW(8), .YW(8), .PB(8), .START_ST(4'b0001)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_rmw(cfg_rmw),
        .cfg_base(cfg_base), .cfg_xlen(cfg_xlen), .cfg_ylen(cfg_ylen),
        .mem_rdy(mem_rdy), .dmnst_b(dmnst_b), .adctlp_b(adctlp_b),
        .dmpst(dmpst), .rmwb(rmwb), .xskip(xskip), .yskip(yskip),
        .page(page), .mem_addr(mem_addr), .mem_req(mem_req), .busy(busy),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Advance one clock and settle 1 time unit past the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        cfg_rmw  = 1'b0;
        cfg_base = '0;
        cfg_xlen = '0;
        cfg_ylen = '0;
        mem_rdy  = 1'b0;
        dmnst_b  = 4'b1111;
        adctlp_b = 3'b111;
        step();
        step();
        rst_n = 1'b1;
        step();

        check("rst_dmpst", 32'(dmpst), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_rmwb", 32'(rmwb), 32'h1);
        check("rst_addr", 32'(mem_addr), 32'h0);
        check("rst_xskip", 32'(xskip), 32'h1);
        check("rst_yskip", 32'(yskip), 32'h1);
        check("rst_page", 32'(page), 32'h0);

        // Start latch
        cfg_base = 16'h1234;
        cfg_xlen = 8'd2;
        cfg_ylen = 8'd1;
        cfg_rmw  = 1'b1;
        start    = 1'b1;
        step();
        start = 1'b0;
        check("st_busy", 32'(busy), 32'h1);
        check("st_req", 32'(mem_req), 32'h1);
        check("st_dmpst", 32'(dmpst), 32'h1);
        check("st_addr", 32'(mem_addr), 32'h1234);
        check("st_rmwb", 32'(rmwb), 32'h0);
        check("st_xskip", 32'(xskip), 32'h0);
        check("st_yskip", 32'(yskip), 32'h0);

        // Increment twice, then row advance with increment
        mem_rdy  = 1'b1;
        dmnst_b  = 4'b1101;
        adctlp_b = 3'b110;
        step();
        check("inc1_addr", 32'(mem_addr), 32'h1235);
        check("inc1_dmpst", 32'(dmpst), 32'h2);
        check("inc1_xskip", 32'(xskip), 32'h0);
        step();
        check("inc2_addr", 32'(mem_addr), 32'h1236);
        check("inc2_xskip", 32'(xskip), 32'h1);
        adctlp_b = 3'b100;
        step();
        check("row_addr", 32'(mem_addr), 32'h1237);
        check("row_xskip", 32'(xskip), 32'h0);
        check("row_yskip", 32'(yskip), 32'h1);

        // Walk up to the last word of the page
        adctlp_b = 3'b110;
        for (int i = 0; i < 200; i++)
            step();
        check("pg_addr", 32'(mem_addr), 32'h12FF);
        check("pg_page", 32'(page), 32'h1);
        check("pg_xskip", 32'(xskip), 32'h1);
        adctlp_b = 3'b010;
        step();
        check("pgx_addr", 32'(mem_addr), 32'h1300);
        check("pgx_page", 32'(page), 32'h0);

        // Stall: everything frozen despite active controls
        mem_rdy  = 1'b0;
        dmnst_b  = 4'b1010;
        adctlp_b = 3'b000;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_addr", 32'(mem_addr), 32'h1300);
            check("stall_dmpst", 32'(dmpst), 32'h2);
            check("stall_busy", 32'(busy), 32'h1);
        end

        // Completion, then restart in the done cycle
        mem_rdy  = 1'b1;
        dmnst_b  = 4'b1111;
        adctlp_b = 3'b111;
        step();
        check("cmp_busy", 32'(busy), 32'h0);
        check("cmp_dmpst", 32'(dmpst), 32'h0);
        check("cmp_done", 32'(done), 32'h1);
        check("cmp_err", 32'(err), 32'h0);
        start   = 1'b1;
        cfg_rmw = 1'b0;
        step();
        start = 1'b0;
        check("rst2_busy", 32'(busy), 32'h1);
        check("rst2_done", 32'(done), 32'h0);
        check("rst2_dmpst", 32'(dmpst), 32'h1);
        check("rst2_addr", 32'(mem_addr), 32'h1234);
        check("rst2_rmwb", 32'(rmwb), 32'h1);

        // Illegal next state
        dmnst_b = 4'b0000;
        step();
        check("ill_dmpst", 32'(dmpst), 32'h0);
        check("ill_busy", 32'(busy), 32'h0);
        check("ill_err", 32'(err), 32'h1);
        check("ill_done", 32'(done), 32'h0);
        step();
        step();
        check("ill_hold_err", 32'(err), 32'h1);
        check("ill_hold_dmpst", 32'(dmpst), 32'h0);
        start = 1'b1;
        step();
        start = 1'b0;
        check("ill_clr_err", 32'(err), 32'h0);
        check("ill_clr_busy", 32'(busy), 32'h1);

        // Asynchronous reset mid-transfer
        dmnst_b = 4'b1010;
        step();
        check("pre_rst_dmpst", 32'(dmpst), 32'h5);
        rst_n = 1'b0;
        #1;
        check("arst_dmpst", 32'(dmpst), 32'h0);
        check("arst_busy", 32'(busy), 32'h0);
        check("arst_addr", 32'(mem_addr), 32'h0);
        check("arst_rmwb", 32'(rmwb), 32'h1);
        check("arst_xskip", 32'(xskip), 32'h1);
        check("arst_yskip", 32'(yskip), 32'h1);
        check("arst_done", 32'(done), 32'h0);
        step();
        check("arst_done2", 32'(done), 32'h0);
        rst_n = 1'b1;
        step();
        check("arst_idle", 32'(busy), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dma_state_seq.md
Name: dma_state_seq

Overview:
- Sequential companion to the combinational DMA next-state/address-control decoder.
- Holds the 4-bit DMA present state and drives it to the decoder as dmpst[3:0].
- Registers the decoder's active-low next state (dmnst_b) and applies its active-low address controls (adctlp_b) to the address and X/Y counters.
- Generates the decoder's condition inputs (xskip, yskip, page, rmwb) and the start/done/memory handshake.

Parameters:
- AW, 16, memory address width.
- XW, 8, X (beats-per-row) counter width.
- YW, 8, Y (row) counter width.
- PB, 8, page size exponent; page = 2^PB words, PB < AW.
- START_ST, 4'b0001, state loaded on start.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse; begin transfer when idle.
- cfg_rmw  in  1  1 = read-modify-write transfer.
- cfg_base  in  AW  start address.
- cfg_xlen  in  XW  beats per row minus 1.
- cfg_ylen  in  YW  rows minus 1.
- mem_rdy  in  1  memory accepted current beat.
- dmnst_b  in  4  decoder next state, active-low.
- adctlp_b  in  3  decoder address controls, active-low: [0] increment, [1] row advance, [2] page advance.
- dmpst  out  4  present state to decoder.
- rmwb  out  1  active-low RMW mode to decoder.
- xskip  out  1  X counter == 0 (last beat of row).
- yskip  out  1  Y counter == 0 (last row).
- page  out  1  addr[PB-1:0] all ones (next increment crosses page).
- mem_addr  out  AW  current address.
- mem_req  out  1  beat request; equals busy.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky illegal-state flag.

Behaviour:
Reset (async, rst_n=0):
- dmpst=0000, busy=0, done=0, err=0, rmwb=1, mem_addr=0; X/Y counters=0.
- Hence xskip=1, yskip=1, page=0.
- Reset mid-transfer aborts immediately; no done pulse.

Idle (busy=0):
- dmpst held at 0000; dmnst_b and adctlp_b are ignored.

Start:
- start=1 while idle in cycle N gives, at N+1: busy=1, dmpst=START_ST, mem_addr=cfg_base, X=cfg_xlen, Y=cfg_ylen, rmwb=~cfg_rmw, err=0.
- cfg_xlen and cfg_ylen are latched for later row reloads.
- start while busy is ignored.

Advance:
- adv = busy & mem_rdy. When mem_rdy=0, all state, address and counters hold.
- On adv: dmpst <= ~dmnst_b.
- Address update, priority order:
  - adctlp_b[2]=0: mem_addr <= {mem_addr[AW-1:PB]+1, PB'b0}.
  - else adctlp_b[0]=0: mem_addr <= mem_addr+1.
  - Address wraps modulo 2^AW with no flag.
- X counter:
  - adctlp_b[1]=0: X <= latched xlen; Y <= Y-1, saturating at 0. This takes priority over the X decrement.
  - else adctlp_b[0]=0: X <= X-1, saturating at 0.
- Page advance and row advance in the same cycle are both applied.

Condition outputs:
- xskip, yskip and page are combinational from the registered counters and address only; there is no input-to-output path, so the decoder loop is exactly one cycle.

Done:
- An adv whose next state (~dmnst_b) is 0000 sets busy=0 and dmpst=0000 at the next edge.
- done=1 for exactly that one following cycle.
- start in the done cycle is accepted (busy is already 0).

Error:
- An adv whose next state is 1111 (illegal) forces dmpst=0000 and busy=0, and sets err=1 instead of done.
- err stays set until the next accepted start or reset.

Test Plan:
- Reset: rst_n low mid-transfer (busy=1, dmpst=0101) -> same cycle: dmpst=0000, busy=0, mem_addr=0, rmwb=1, xskip=yskip=1; no done pulse.
- Start latch: cfg_base=0x1234, xlen=2, ylen=1, cfg_rmw=1, start at cycle 5 -> cycle 6: busy=1, dmpst=0001, mem_addr=0x1234, rmwb=0, xskip=0, yskip=0.
- Increment and row reload: hold adctlp_b=110 with mem_rdy=1 for 2 cycles -> addr 0x1236, X=0, xskip=1. Then adctlp_b=100 -> addr 0x1237, X=2, Y=0, yskip=1.
- Page crossing: mem_addr=0x12FF gives page=1. adctlp_b=010 plus adv -> mem_addr=0x1300, page=0. Stall: mem_rdy=0 for 3 cycles -> all outputs frozen.
- Completion: dmnst_b=1111 (next state 0000) with adv -> next cycle busy=0, dmpst=0000, done=1 for one cycle. start in that cycle -> busy=1 the following cycle.
- Illegal: dmnst_b=0000 (next state 1111) with adv -> dmpst=0000, busy=0, err=1, done=0. err stays 1 until the next start clears it.
